// File: rtl/pulse_xfer_pkg.sv
// Shared types for the pulse transfer arbiter.
// Holds the FSM state enum and counter widths.
package pulse_xfer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        ARM,
        WAIT,
        GUARD
    } pulse_arb_state_t;

    localparam int MERGE_CNT_W = 8;

    // Guard counter width; a zero guard still needs one bit.
    function automatic int guard_cnt_w(input int g);
        return (g > 0) ? $clog2(g + 1) : 1;
    endfunction

endpackage

// File: rtl/pulse_xfer_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Returns the lowest pending index at or above rr_ptr, wrapping.
module rr_pick
    import pulse_xfer_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] pending,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_vld
);

    localparam logic [ID_W:0] N_W = (ID_W + 1)'(NUM_REQ);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;

    // Scan from the farthest offset down so the nearest hit wins.
    always_comb begin
        grant_idx = '0;
        grant_vld = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + (ID_W + 1)'(k);
            if (sum >= N_W) begin
                sum = sum - N_W;
            end
            idx = sum[ID_W-1:0];
            if (pending[idx]) begin
                grant_idx = idx;
                grant_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pulse_xfer_arbiter.sv
// Round-robin scheduler sharing one pulse transfer channel.
// Optional merge counter: define PULSE_XFER_ARB_MERGE_CNT_EN.
module pulse_xfer_arbiter
    import pulse_xfer_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int GUARD_CYCLES = 8,
    parameter int ID_W         = $clog2(NUM_REQ)
) (
    input  logic               src_clock,
    input  logic               src_reset,
    input  logic [NUM_REQ-1:0] req_pulse,
    input  logic               xfer_busy,
    output logic               xfer_pulse,
    output logic [ID_W-1:0]    xfer_id,
    output logic [NUM_REQ-1:0] pending
`ifdef PULSE_XFER_ARB_MERGE_CNT_EN
    ,
    output logic [MERGE_CNT_W-1:0] merge_cnt
`endif
);

    localparam int GW = guard_cnt_w(GUARD_CYCLES);
    localparam logic [ID_W-1:0] LAST_ID    = ID_W'(NUM_REQ - 1);
    localparam logic [GW-1:0]   GUARD_LOAD = GW'(GUARD_CYCLES);
    localparam logic [GW-1:0]   GUARD_ONE  = GW'(1);

    pulse_arb_state_t state;
    pulse_arb_state_t state_nxt;

    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    pick_idx;
    logic               pick_vld;
    logic               grant_en;
    logic               pulse_nxt;
    logic [NUM_REQ-1:0] grant_mask;
    logic [GW-1:0]      gcnt;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .pending   (pending),
        .rr_ptr    (rr_ptr),
        .grant_idx (pick_idx),
        .grant_vld (pick_vld)
    );

    // State register.
    always_ff @(posedge src_clock) begin
        if (src_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, grant strobe and the pulse to be registered.
    always_comb begin
        state_nxt = state;
        grant_en  = 1'b0;
        pulse_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_vld) begin
                    grant_en  = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = ARM;
            ARM:   state_nxt = WAIT;
            WAIT: begin
                if (!xfer_busy) begin
                    state_nxt = (GUARD_CYCLES == 0) ? IDLE : GUARD;
                end
            end
            GUARD: begin
                if (gcnt <= GUARD_ONE) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        pulse_nxt = (state_nxt == ISSUE);
    end

    // One-hot of the index being granted this cycle.
    always_comb begin
        grant_mask = '0;
        if (grant_en) begin
            grant_mask[pick_idx] = 1'b1;
        end
    end

    // Pending events: a same-cycle request re-arms the granted bit.
    always_ff @(posedge src_clock) begin
        if (src_reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~grant_mask) | req_pulse;
        end
    end

    // Issue pulse, quasi-static id bus and round-robin pointer.
    always_ff @(posedge src_clock) begin
        if (src_reset) begin
            xfer_pulse <= 1'b0;
            xfer_id    <= '0;
            rr_ptr     <= '0;
        end else begin
            xfer_pulse <= pulse_nxt;
            if (grant_en) begin
                xfer_id <= pick_idx;
                rr_ptr  <= (pick_idx == LAST_ID) ? '0 : pick_idx + 1'b1;
            end
        end
    end

    // Guard countdown, loaded as the channel goes idle.
    always_ff @(posedge src_clock) begin
        if (src_reset) begin
            gcnt <= '0;
        end else if (state == WAIT && !xfer_busy) begin
            gcnt <= GUARD_LOAD;
        end else if (state == GUARD && gcnt != '0) begin
            gcnt <= gcnt - GUARD_ONE;
        end
    end

`ifdef PULSE_XFER_ARB_MERGE_CNT_EN
    logic [NUM_REQ-1:0]     merge_hits;
    logic [MERGE_CNT_W-1:0] merge_inc;
    logic [MERGE_CNT_W:0]   merge_sum;

    // Events landing on an already pending bit, excluding a collision.
    always_comb begin
        merge_hits = req_pulse & pending & ~grant_mask;
        merge_inc  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            merge_inc = merge_inc + MERGE_CNT_W'(merge_hits[i]);
        end
        merge_sum = {1'b0, merge_cnt} + {1'b0, merge_inc};
    end

    // Saturating merge counter, cleared only by reset.
    always_ff @(posedge src_clock) begin
        if (src_reset) begin
            merge_cnt <= '0;
        end else if (merge_sum[MERGE_CNT_W]) begin
            merge_cnt <= '1;
        end else begin
            merge_cnt <= merge_sum[MERGE_CNT_W-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_pulse_xfer_arbiter.sv
// Bench for pulse_xfer_arbiter: timestamp model plus directed scenarios.
// Merge checks run when PULSE_XFER_ARB_MERGE_CNT_EN is defined.
module tb_pulse_xfer_arbiter;

    localparam int N = 4;
    localparam int G = 8;
    localparam int BUSY_LEN = 6;

    logic       clk = 1'b0;
    logic       src_reset = 1'b1;
    logic [3:0] req_pulse = '0;
    logic       xfer_busy;
    logic       xfer_pulse;
    logic [1:0] xfer_id;
    logic [3:0] pending;
`ifdef PULSE_XFER_ARB_MERGE_CNT_EN
    logic [7:0] merge_cnt;
`endif

    pulse_xfer_arbiter #(
        .NUM_REQ      (N),
        .GUARD_CYCLES (G)
    ) dut (
        .src_clock  (clk),
        .src_reset  (src_reset),
        .req_pulse  (req_pulse),
        .xfer_busy  (xfer_busy),
        .xfer_pulse (xfer_pulse),
        .xfer_id    (xfer_id),
        .pending    (pending)
`ifdef PULSE_XFER_ARB_MERGE_CNT_EN
        ,
        .merge_cnt  (merge_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Channel model: busy for BUSY_LEN cycles after each pulse.
    int bcnt = 0;
    always @(posedge clk) begin
        if (xfer_pulse === 1'b1) bcnt <= BUSY_LEN;
        else if (bcnt > 0) bcnt <= bcnt - 1;
    end
    assign xfer_busy = (bcnt != 0);

    int n_cmp = 0;
    int n_fail = 0;
    int base = 0;
    int lc[$];
    int li[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // Model state
    bit         armed = 0;
    logic [3:0] m_pend;
    logic [1:0] m_id;
    logic       m_pulse;
    int         m_rr;
    int         m_ok;
    int         m_watch;
    int         m_mc;

    function automatic int pick(input logic [3:0] p, input int rr);
        int r;
        bit hit;
        r = -1;
        hit = 0;
        for (int k = 0; k < N; k++) begin
            if (!hit && p[(rr + k) % N]) begin
                r = (rr + k) % N;
                hit = 1;
            end
        end
        return r;
    endfunction

    // Compare this cycle, then advance the model to the next cycle.
    always @(negedge clk) begin
        int g;
        logic [3:0] gm;
        if (armed) begin
            chk("pulse", {31'd0, xfer_pulse}, {31'd0, m_pulse});
            chk("id", {30'd0, xfer_id}, {30'd0, m_id});
            chk("pending", {28'd0, pending}, {28'd0, m_pend});
`ifdef PULSE_XFER_ARB_MERGE_CNT_EN
            chk("merge_cnt", {24'd0, merge_cnt}, m_mc);
`endif
        end
        if (xfer_pulse === 1'b1) begin
            lc.push_back(cyc - base);
            li.push_back(int'(xfer_id));
        end
        if (src_reset) begin
            armed = 1;
            m_pend = '0;
            m_id = '0;
            m_pulse = 1'b0;
            m_rr = 0;
            m_ok = 0;
            m_watch = 0;
            m_mc = 0;
        end else if (armed) begin
            if (m_ok < 0 && cyc >= m_watch && !xfer_busy) m_ok = cyc + 1 + G;
            g = -1;
            gm = '0;
            if (m_ok >= 0 && cyc >= m_ok && m_pend != 0) begin
                g = pick(m_pend, m_rr);
                gm[g] = 1'b1;
            end
            m_mc = m_mc + $countones(req_pulse & m_pend & ~gm);
            if (m_mc > 255) m_mc = 255;
            m_pend = (m_pend & ~gm) | req_pulse;
            m_pulse = (g >= 0);
            if (g >= 0) begin
                m_id = 2'(g);
                m_rr = (g + 1) % N;
                m_ok = -1;
                m_watch = cyc + 3;
            end
        end
    end

    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int c, input logic [3:0] v, input int len);
        wait_to(c);
        req_pulse = v;
        repeat (len) begin
            @(posedge clk);
            #1;
        end
        req_pulse = '0;
    endtask

    task automatic do_reset;
        src_reset = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        src_reset = 1'b0;
        base = cyc;
        lc.delete();
        li.delete();
    endtask

    task automatic check_log(input int i, input int c, input int id);
        chk("log_cyc", (i < lc.size()) ? lc[i] : -1, c);
        chk("log_id", (i < li.size()) ? li[i] : -1, id);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Single event and reset values
        do_reset();
        @(negedge clk);
        chk("rst_pulse", {31'd0, xfer_pulse}, 0);
        chk("rst_id", {30'd0, xfer_id}, 0);
        chk("rst_pend", {28'd0, pending}, 0);
        drive(base + 10, 4'b0001, 1);
        wait_to(base + 11);
        @(negedge clk);
        chk("single_pend11", {28'd0, pending}, 4'b0001);
        wait_to(base + 40);
        chk("single_cnt", lc.size(), 1);
        check_log(0, 12, 0);

        // Simultaneous events
        do_reset();
        drive(base + 10, 4'b1111, 1);
        wait_to(base + 80);
        check_log(0, 12, 0);
        check_log(1, 29, 1);
        check_log(2, 46, 2);
        check_log(3, 63, 3);

        // Fairness
        do_reset();
        drive(base + 10, 4'b0101, 1);
        drive(base + 11, 4'b0001, 40);
        wait_to(base + 70);
        check_log(0, 12, 0);
        check_log(1, 29, 2);
        check_log(2, 46, 0);

        // Collision
        do_reset();
        drive(base + 10, 4'b0010, 2);
        wait_to(base + 12);
        @(negedge clk);
        chk("coll_pend12", {28'd0, pending}, 4'b0010);
        wait_to(base + 40);
        check_log(0, 12, 1);
        check_log(1, 29, 1);

        // Reset during WAIT
        do_reset();
        drive(base + 10, 4'b0001, 1);
        drive(base + 13, 4'b0110, 1);
        wait_to(base + 16);
        @(negedge clk);
        chk("wait_pend", {28'd0, pending}, 4'b0110);
        wait_to(base + 16);
        src_reset = 1'b1;
        @(posedge clk);
        #1;
        src_reset = 1'b0;
        @(negedge clk);
        chk("mr_pend", {28'd0, pending}, 0);
        chk("mr_id", {30'd0, xfer_id}, 0);
        chk("mr_pulse", {31'd0, xfer_pulse}, 0);
        wait_to(base + 40);
        chk("mr_quiet", lc.size(), 1);
        drive(base + 40, 4'b1000, 1);
        wait_to(base + 50);
        check_log(1, 42, 3);

`ifdef PULSE_XFER_ARB_MERGE_CNT_EN
        // Merge counting and saturation
        do_reset();
        drive(base + 10, 4'b0001, 1);
        drive(base + 12, 4'b1000, 1);
        drive(base + 14, 4'b1000, 3);
        wait_to(base + 20);
        @(negedge clk);
        chk("merge3", {24'd0, merge_cnt}, 3);
        wait_to(base + 58);
        chk("merge_issues", lc.size(), 2);
        check_log(1, 29, 3);
        drive(base + 60, 4'b0001, 1);
        drive(base + 62, 4'b1000, 300);
        wait_to(base + 370);
        @(negedge clk);
        chk("merge_sat", {24'd0, merge_cnt}, 255);
`endif

        wait_to(cyc + 2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
